snake_move_ctrl: RTL

Turns keyboard codes and frame ticks into timed movement commands for the snake datapath. It sits between the PS2 keyboard receiver and the snake position/render logic. It decodes arrow keys and rejects 180° reversals. Up to two pending turns are buffered so quick key sequences are not lost. Once every `FRAMES_PER_STEP` frames it emits a one-cycle `step` pulse with the direction the head must move on that step.

---
 rtl/snake_move_ctrl_if.sv | 26 ++
 rtl/snake_move_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/snake_move_ctrl_if.sv
// Bundle of signals between the keyboard/game side and snake_move_ctrl.
//   key_valid/key_code : one-cycle scan-code strobe from the PS2 receiver
//   frame_tick         : one-cycle pulse per video frame
//   init, pause        : level controls from the game FSM
//   step, dir, pending : movement command back to the snake datapath
// master drives keys/controls and observes the command; slave is the controller.
interface snake_move_ctrl_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       frame_tick;
  logic       init;
  logic       pause;
  logic       step;
  logic [1:0] dir;
  logic [1:0] pending;

  modport master (
    output key_valid, key_code, frame_tick, init, pause,
    input  step, dir, pending
  );

  modport slave (
    input  key_valid, key_code, frame_tick, init, pause,
    output step, dir, pending
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: turns arrow-key scan codes and frame ticks into timed
// snake movement commands.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : snake_move_ctrl_if.slave (keys, frame_tick, init, pause in;
//          step pulse, registered heading dir, buffered turn count pending out)
// Turns are buffered in a 2-entry FIFO; a turn is rejected if it repeats or
// reverses the most recent heading (the queued tail, or dir when empty).
// Every FRAMES_PER_STEP unpaused frame ticks a step fires and pops one turn.
module snake_move_ctrl #(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic                clk,
  input  logic                rst,
  snake_move_ctrl_if.slave    bus
);

  localparam logic [5:0] FCNT_LAST = 6'(FRAMES_PER_STEP - 1);

  logic [5:0] fcnt_q, fcnt_d;
  logic       step_q, step_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] slot0_q, slot0_d;   // FIFO head
  logic [1:0] slot1_q, slot1_d;   // second entry, valid when cnt_q == 2

  logic       key_ok;
  logic [1:0] key_dir;
  logic       fire;
  logic       pop;
  logic [1:0] cnt_after_pop;
  logic [1:0] ref_dir;
  logic       accept;

  always_comb begin
    key_ok  = 1'b1;
    key_dir = 2'b00;
    unique case (bus.key_code)
      8'h74:   key_dir = 2'b00;
      8'h6B:   key_dir = 2'b01;
      8'h72:   key_dir = 2'b10;
      8'h75:   key_dir = 2'b11;
      default: key_ok  = 1'b0;
    endcase
  end

  always_comb begin
    fire          = bus.frame_tick && !bus.pause && !bus.init && (fcnt_q == FCNT_LAST);
    pop           = fire && (cnt_q != 2'd0);
    cnt_after_pop = cnt_q - {1'b0, pop};

    // The tail is unchanged by a pop unless the FIFO empties, in which case the
    // popped head is the tail anyway, so the pre-pop tail covers both cases.
    if (cnt_q == 2'd2)      ref_dir = slot1_q;
    else if (cnt_q == 2'd1) ref_dir = slot0_q;
    else                    ref_dir = dir_q;

    // Same or opposite heading differs only in bit 0, so bit 1 must change.
    accept = bus.key_valid && key_ok && !bus.init
             && (key_dir != ref_dir)
             && (key_dir != (ref_dir ^ 2'b01))
             && (cnt_after_pop != 2'd2);

    fcnt_d  = fcnt_q;
    step_d  = fire;
    dir_d   = dir_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_after_pop;

    if (bus.frame_tick && !bus.pause) begin
      fcnt_d = (fcnt_q == FCNT_LAST) ? 6'd0 : fcnt_q + 6'd1;
    end

    if (pop) begin
      dir_d   = slot0_q;
      slot0_d = slot1_q;
    end

    if (accept) begin
      if (cnt_after_pop == 2'd0) slot0_d = key_dir;
      else                       slot1_d = key_dir;
      cnt_d = cnt_after_pop + 2'd1;
    end

    if (bus.init) begin
      fcnt_d  = 6'd0;
      step_d  = 1'b0;
      dir_d   = 2'b00;
      cnt_d   = 2'd0;
      slot0_d = 2'b00;
      slot1_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= 6'd0;
      step_q  <= 1'b0;
      dir_q   <= 2'b00;
      cnt_q   <= 2'd0;
      slot0_q <= 2'b00;
      slot1_q <= 2'b00;
    end else begin
      fcnt_q  <= fcnt_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.dir     = dir_q;
  assign bus.pending = cnt_q;

endmodule
